prog_load_run_ctrl: RTL and testbench

- Sequences the single-cycle RISC-V datapath through two phases: program load, then run.
- Load phase: accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into instruction memory from word address 0.
- Run phase: releases the core's reset, counts cycles, and stops the core on EBREAK or on a cycle limit. Captures the halt PC and reports status.
- Sits between the testbench/host loader and the datapath's rst_n input and instruction-memory write port.

---
 rtl/prog_load_run_ctrl.sv | 138 +++++++++++++
 tb/tb_prog_load_run_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_load_run_ctrl.sv
// Load/run sequencer for the single-cycle RISC-V datapath: streams a program into
// instruction memory, releases the core, then stops it on EBREAK or a cycle limit.
//
// Handshake: a loader word transfers on a rising clk edge where s_valid && s_ready;
// s_ready is high exactly while in LOAD, and s_data must be stable while s_valid is high.
module prog_load_run_ctrl #(
  parameter int          ADDR_W = 8,
  parameter int          CNT_W  = 16,
  parameter logic [31:0] EBREAK = 32'h00100073
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [CNT_W-1:0]  cycle_limit,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  input  logic [31:0]       core_pc,
  input  logic [31:0]       core_instr,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [31:0]       halt_pc,
  output logic [CNT_W-1:0]  run_cycles,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_EBREAK  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_BAD_LEN = 2'b11;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W:0]   len_q;
  logic [CNT_W-1:0]  limit_q;

  logic beat;
  logic bad_len;
  logic last_beat;
  logic limit_hit;

  assign s_ready    = (state == S_LOAD);
  assign core_rst_n = (state == S_RUN);
  assign busy       = (state == S_LOAD) || (state == S_RELEASE) || (state == S_RUN);
  assign state_dbg  = state;

  assign beat      = s_valid && s_ready;
  assign bad_len   = (load_len == '0) || (load_len > MAX_LEN);
  assign last_beat = ({1'b0, cnt} == (len_q - 1'b1));
  // run_cycles still holds the pre-increment count here, so limit-1 ends the run after limit cycles
  assign limit_hit = (limit_q != '0) && (run_cycles == (limit_q - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      len_q      <= '0;
      limit_q    <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      status     <= ST_NONE;
      halt_pc    <= '0;
      run_cycles <= '0;
    end else begin
      done    <= 1'b0;
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            if (bad_len) begin
              state  <= S_HALT;
              status <= ST_BAD_LEN;
              done   <= 1'b1;
            end else begin
              state      <= S_LOAD;
              len_q      <= load_len;
              limit_q    <= cycle_limit;
              run_cycles <= '0;
              status     <= ST_NONE;
              halt_pc    <= '0;
              cnt        <= '0;
            end
          end
        end
        S_LOAD: begin
          if (beat) begin
            imem_we    <= 1'b1;
            imem_waddr <= cnt;
            imem_wdata <= s_data;
            cnt        <= cnt + 1'b1;
            if (last_beat) begin
              state <= S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          state <= S_RUN;
        end
        S_RUN: begin
          if (run_cycles != '1) begin
            run_cycles <= run_cycles + 1'b1;
          end
          if (core_instr == EBREAK) begin
            state   <= S_HALT;
            status  <= ST_EBREAK;
            halt_pc <= core_pc;
            done    <= 1'b1;
          end else if (limit_hit) begin
            state   <= S_HALT;
            status  <= ST_TIMEOUT;
            halt_pc <= core_pc;
            done    <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_load_run_ctrl.sv
// Bench for prog_load_run_ctrl: a tiny fetch-only core stub plus an
// instruction-level reference model of load, run and halt outcomes.
module tb_prog_load_run_ctrl;

  localparam int          ADDR_W = 8;
  localparam int          CNT_W  = 16;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] JAL0   = 32'h0000006F;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic [CNT_W-1:0]  cycle_limit = '0;
  logic              s_valid = 1'b0;
  logic [31:0]       s_data = '0;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic [31:0]       core_pc;
  logic [31:0]       core_instr;
  logic              busy;
  logic              done;
  logic [1:0]        status;
  logic [31:0]       halt_pc;
  logic [CNT_W-1:0]  run_cycles;
  logic [2:0]        state_dbg;

  prog_load_run_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .EBREAK(EBREAK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len),
    .cycle_limit(cycle_limit), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .core_rst_n(core_rst_n), .core_pc(core_pc),
    .core_instr(core_instr), .busy(busy), .done(done), .status(status),
    .halt_pc(halt_pc), .run_cycles(run_cycles), .state_dbg(state_dbg)
  );

  // core stub: memory written by the controller, pc steps by 4 except on jal x0,0
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  initial for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
  always @(posedge clk) if (imem_we) mem[imem_waddr] <= imem_wdata;
  assign core_instr = mem[core_pc[ADDR_W+1:2]];
  always @(posedge clk) begin
    if (!core_rst_n) core_pc <= '0;
    else if (core_instr != JAL0) core_pc <= core_pc + 32'd4;
  end

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0] model_mem [0:(1<<ADDR_W)-1];
  logic [31:0] prog[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (exp_q.size() == 0) chk("unexpected_write", 32'(imem_waddr), 32'hFFFF_FFFF);
      else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        chk("waddr", 32'(imem_waddr), 32'(e[ADDR_W+31:32]));
        chk("wdata", imem_wdata, e[31:0]);
      end
    end
  end

  // reference: step instructions from word 0 until EBREAK or the cycle limit
  task automatic model_run(input int limit, output logic [1:0] st, output logic [31:0] hpc,
                           output logic [31:0] rc);
    logic [31:0] pc;
    logic [31:0] instr;
    pc = 0; st = 2'b00; hpc = 0; rc = 0;
    for (int k = 0; k < 70000; k++) begin
      instr = model_mem[pc[ADDR_W+1:2]];
      rc = (k + 1 > 65535) ? 32'd65535 : 32'(k + 1);
      if (instr == EBREAK) begin st = 2'b01; hpc = pc; return; end
      if (limit != 0 && k == limit - 1) begin st = 2'b10; hpc = pc; return; end
      if (instr != JAL0) pc = pc + 4;
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    do w = $urandom; while (w == EBREAK || w == JAL0);
    return w;
  endfunction

  task automatic do_reset_check(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_ctrl"}, 32'({s_ready, imem_we, core_rst_n, busy, done, status}), 32'd0);
    chk({tag, "_waddr"}, 32'(imem_waddr), 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_halt_pc"}, halt_pc, 32'd0);
    chk({tag, "_run_cycles"}, 32'(run_cycles), 32'd0);
    exp_q.delete();
    start = 1'b0; s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // driver: one start + load + run sequence using the words in prog
  task automatic run_seq(input int len, input int limit, input bit toggle, input bit poke,
                         input int rst_at);
    int idx, guard;
    bit phase, v;
    logic [1:0] est;
    logic [31:0] ehpc, erc;
    @(negedge clk);
    start = 1'b1; load_len = (ADDR_W+1)'(len); cycle_limit = CNT_W'(limit);
    @(negedge clk);
    start = 1'b0;
    if (len == 0 || len > (1 << ADDR_W)) begin
      chk("bad_done", 32'(done), 32'd1);
      chk("bad_status", 32'(status), 32'd3);
      chk("bad_core_rst", 32'(core_rst_n), 32'd0);
      chk("bad_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("bad_done_pulse", 32'(done), 32'd0);
      chk("bad_status_hold", 32'(status), 32'd3);
      chk("bad_no_write", 32'(exp_q.size()), 32'd0);
      return;
    end
    chk("load_status_clr", 32'(status), 32'd0);
    chk("load_halt_pc_clr", halt_pc, 32'd0);
    chk("load_cycles_clr", 32'(run_cycles), 32'd0);
    chk("load_busy", 32'(busy), 32'd1);
    idx = 0; guard = 0; phase = 1'b0;
    while (idx < len) begin
      v = toggle ? phase : 1'b1;
      phase = ~phase;
      s_valid = v;
      s_data = v ? prog[idx] : $urandom;
      if (v && s_ready) begin
        exp_q.push_back({ADDR_W'(idx), prog[idx]});
        model_mem[idx] = prog[idx];
        idx++;
      end
      @(negedge clk);
      guard++;
      if (guard > 2000) begin chk("load_timeout", 32'(idx), 32'(len)); s_valid = 1'b0; return; end
    end
    s_valid = 1'b0;
    chk("ready_after_last", 32'(s_ready), 32'd0);
    chk("release_core_rst", 32'(core_rst_n), 32'd0);
    chk("release_busy", 32'(busy), 32'd1);
    model_run(limit, est, ehpc, erc);
    @(negedge clk);
    guard = 0;
    while (!done) begin
      chk("run_core_rst", 32'(core_rst_n), 32'd1);
      if (rst_at >= 0 && int'(run_cycles) == rst_at) begin
        do_reset_check("midrun_rst");
        return;
      end
      if (poke) begin start = (guard == 2); load_len = '0; end
      @(negedge clk);
      guard++;
      if (guard > 5000) begin chk("run_timeout", 32'(done), 32'd1); start = 1'b0; return; end
    end
    start = 1'b0;
    chk("halt_status", 32'(status), 32'(est));
    chk("halt_pc", halt_pc, ehpc);
    chk("halt_cycles", 32'(run_cycles), erc);
    chk("halt_core_rst", 32'(core_rst_n), 32'd0);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("status_hold", 32'(status), 32'(est));
    chk("cycles_hold", 32'(run_cycles), erc);
  endtask

  initial begin
    int len, lim;
    for (int i = 0; i < (1 << ADDR_W); i++) model_mem[i] = '0;
    // reset state
    #2;
    do_reset_check("reset");

    // program with two addi then EBREAK
    prog = '{32'h00500093, 32'h00A00113, EBREAK};
    run_seq(3, 0, 1'b0, 1'b0, -1);
    chk("tp1_status", 32'(status), 32'd1);
    chk("tp1_halt_pc", halt_pc, 32'h8);
    chk("tp1_cycles", 32'(run_cycles), 32'd3);

    // four words with s_valid toggling
    prog = '{rand_word(), rand_word(), rand_word(), EBREAK};
    run_seq(4, 0, 1'b1, 1'b0, -1);

    // jal x0,0 loop against a cycle limit
    prog = '{JAL0};
    run_seq(1, 10, 1'b0, 1'b0, -1);
    chk("tp3_status", 32'(status), 32'd2);
    chk("tp3_cycles", 32'(run_cycles), 32'd10);
    chk("tp3_halt_pc", halt_pc, 32'd0);

    // bad lengths: zero and one past the memory depth
    run_seq(0, 0, 1'b0, 1'b0, -1);
    run_seq((1 << ADDR_W) + 1, 0, 1'b0, 1'b0, -1);

    // reset mid-run, then a clean sequence
    prog = '{32'h00500093, JAL0};
    run_seq(2, 0, 1'b0, 1'b0, 5);
    prog = '{32'h00500093, 32'h00A00113, EBREAK};
    run_seq(3, 0, 1'b0, 1'b0, -1);

    // start pulsed during RUN must be ignored
    prog.delete();
    for (int i = 0; i < 20; i++) prog.push_back(rand_word());
    prog.push_back(EBREAK);
    run_seq(21, 0, 1'b0, 1'b1, -1);

    // EBREAK wins when it coincides with the limit; limit of one cycle
    prog = '{rand_word(), rand_word(), EBREAK};
    run_seq(3, 3, 1'b0, 1'b0, -1);
    run_seq(3, 1, 1'b0, 1'b0, -1);

    // full-depth load
    prog.delete();
    for (int i = 0; i < (1 << ADDR_W) - 1; i++) prog.push_back(rand_word());
    prog.push_back(EBREAK);
    run_seq(1 << ADDR_W, 0, 1'b1, 1'b0, -1);

    // random programs
    for (int t = 0; t < 15; t++) begin
      len = $urandom_range(1, 12);
      lim = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 25);
      prog.delete();
      for (int i = 0; i < len - 1; i++)
        prog.push_back(($urandom_range(0, 7) == 0) ? EBREAK : rand_word());
      prog.push_back((lim == 0 || $urandom_range(0, 1) == 0) ? EBREAK : JAL0);
      run_seq(len, lim, 1'($urandom_range(0, 1)), 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
